// File: rtl/clg_resp_checker.sv
// Self-checking response monitor for a WIDTH-bit carry-lookahead generator.
// Latches golden carries on accept, waits SETTLE cycles, then compares dut_c.
module clg_resp_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] g_in,
    input  logic             c0_in,
    input  logic [WIDTH-1:0] dut_c,
    output logic [WIDTH-1:0] exp_c,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMPARE
    } state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q;
    logic [3:0]       settle_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_d;
    logic             done_q;
    logic             mismatch_q;
    logic             mismatch_d;
    logic             pass_q;
    logic             pass_d;
    logic [CNT_W-1:0] vec_cnt_q;
    logic [CNT_W-1:0] vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    // Ripple form of the lookahead equations: c[i+1] = g[i] | p[i] & c[i].
    function automatic logic [WIDTH-1:0] clg_carries(input logic [WIDTH-1:0] p,
                                                     input logic [WIDTH-1:0] g,
                                                     input logic             c0);
        logic [WIDTH:0] c;
        c[0] = c0;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return c[WIDTH:1];
    endfunction

    assign vec_ready = (state_q == IDLE) && !clear;

    // Post-update counts feed pass so it tracks the counters on the same edge.
    always_comb begin
        exp_d      = clg_carries(p_in, g_in, c0_in);
        mismatch_d = (dut_c != exp_q);
        vec_cnt_d  = (vec_cnt_q == CNT_MAX) ? vec_cnt_q : vec_cnt_q + CNT_W'(1);
        err_cnt_d  = (mismatch_d && (err_cnt_q != CNT_MAX)) ? err_cnt_q + CNT_W'(1)
                                                            : err_cnt_q;
        pass_d     = (vec_cnt_d != '0) && (err_cnt_d == '0);
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            exp_q      <= '0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            pass_q     <= 1'b0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else if (clear) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            pass_q     <= 1'b0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vec_valid) begin
                        exp_q    <= exp_d;
                        settle_q <= SETTLE_LD;
                        state_q  <= (SETTLE > 0) ? WAIT : COMPARE;
                    end
                end
                WAIT: begin
                    if (settle_q == 4'd1) begin
                        settle_q <= '0;
                        state_q  <= COMPARE;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                COMPARE: begin
                    mismatch_q <= mismatch_d;
                    vec_cnt_q  <= vec_cnt_d;
                    err_cnt_q  <= err_cnt_d;
                    pass_q     <= pass_d;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign exp_c    = exp_q;
    assign done     = done_q;
    assign mismatch = mismatch_q;
    assign vec_cnt  = vec_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_clg_resp_checker.sv
// Bench for clg_resp_checker: three builds (SETTLE=2, SETTLE=0, CNT_W=2) checked
// every cycle against a countdown-based behavioural model plus literal checks.
module tb_clg_resp_checker;

    localparam int NI = 3;

    localparam logic [3:0] TP [6] = '{4'b1101, 4'b1100, 4'b0101, 4'b1100, 4'b0101, 4'b1011};
    localparam logic [3:0] TG [6] = '{4'b0101, 4'b1000, 4'b1101, 4'b1100, 4'b0101, 4'b1011};
    localparam logic       TC [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [3:0] TE [6] = '{4'b1101, 4'b1000, 4'b1101, 4'b1100, 4'b0101, 4'b1011};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear     [NI];
    logic       vec_valid [NI];
    logic [3:0] p_in      [NI];
    logic [3:0] g_in      [NI];
    logic       c0_in     [NI];
    logic [3:0] dut_c     [NI];
    logic [3:0] fault_q   [NI];

    logic       rdy    [NI];
    logic [3:0] expc   [NI];
    logic       done_o [NI];
    logic       mism   [NI];
    logic       pass_o [NI];
    logic [7:0] vc0, vc1, ec0, ec1;
    logic [1:0] vc2, ec2;
    logic [7:0] vc_a [NI];
    logic [7:0] ec_a [NI];

    int         m_busy [NI];
    logic [3:0] m_exp  [NI];
    logic       m_done [NI];
    logic       m_mism [NI];
    logic       m_pass [NI];
    int         m_vc   [NI];
    int         m_ec   [NI];
    bit         started = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    clg_resp_checker #(.WIDTH(4), .SETTLE(2), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]), .vec_valid(vec_valid[0]),
        .vec_ready(rdy[0]), .p_in(p_in[0]), .g_in(g_in[0]), .c0_in(c0_in[0]),
        .dut_c(dut_c[0]), .exp_c(expc[0]), .done(done_o[0]), .mismatch(mism[0]),
        .vec_cnt(vc0), .err_cnt(ec0), .pass(pass_o[0]));

    clg_resp_checker #(.WIDTH(4), .SETTLE(0), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]), .vec_valid(vec_valid[1]),
        .vec_ready(rdy[1]), .p_in(p_in[1]), .g_in(g_in[1]), .c0_in(c0_in[1]),
        .dut_c(dut_c[1]), .exp_c(expc[1]), .done(done_o[1]), .mismatch(mism[1]),
        .vec_cnt(vc1), .err_cnt(ec1), .pass(pass_o[1]));

    clg_resp_checker #(.WIDTH(4), .SETTLE(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear[2]), .vec_valid(vec_valid[2]),
        .vec_ready(rdy[2]), .p_in(p_in[2]), .g_in(g_in[2]), .c0_in(c0_in[2]),
        .dut_c(dut_c[2]), .exp_c(expc[2]), .done(done_o[2]), .mismatch(mism[2]),
        .vec_cnt(vc2), .err_cnt(ec2), .pass(pass_o[2]));

    always_comb begin
        vc_a[0] = vc0;
        vc_a[1] = vc1;
        vc_a[2] = {6'd0, vc2};
        ec_a[0] = ec0;
        ec_a[1] = ec1;
        ec_a[2] = {6'd0, ec2};
    end

    function automatic int settle_of(input int k);
        return (k == 1) ? 0 : 2;
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 2) ? 3 : 255;
    endfunction

    // Carries of the addition (p|g) + g + c0: carry into bit j is sum^a^b at bit j.
    function automatic logic [3:0] golden(input logic [3:0] p, input logic [3:0] g,
                                          input logic c0);
        logic [3:0] a;
        logic [5:0] s;
        logic [5:0] t;
        a = p | g;
        s = {2'b00, a} + {2'b00, g} + {5'd0, c0};
        t = s ^ {2'b00, a ^ g};
        return t[4:1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model: a vector in flight is a countdown to its compare edge.
    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_busy[k] = 0; m_exp[k] = '0; m_done[k] = 1'b0; m_mism[k] = 1'b0;
                m_vc[k] = 0; m_ec[k] = 0; m_pass[k] = 1'b0;
            end else if (clear[k]) begin
                m_busy[k] = 0; m_done[k] = 1'b0; m_mism[k] = 1'b0;
                m_vc[k] = 0; m_ec[k] = 0; m_pass[k] = 1'b0;
            end else begin
                m_done[k] = 1'b0;
                if (m_busy[k] > 0) begin
                    m_busy[k]--;
                    if (m_busy[k] == 0) begin
                        m_mism[k] = (dut_c[k] != m_exp[k]);
                        if (m_vc[k] < cmax_of(k)) m_vc[k]++;
                        if (m_mism[k] && m_ec[k] < cmax_of(k)) m_ec[k]++;
                        m_pass[k] = (m_vc[k] != 0) && (m_ec[k] == 0);
                        m_done[k] = 1'b1;
                    end
                end else if (vec_valid[k]) begin
                    m_exp[k]  = golden(p_in[k], g_in[k], c0_in[k]);
                    m_busy[k] = settle_of(k) + 1;
                end
            end
        end
        started = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Emulated DUT: correct carries (xor a fault mask) while a vector is in flight, junk otherwise.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            if (m_busy[k] != 0) dut_c[k] = m_exp[k] ^ fault_q[k];
            else                dut_c[k] = 4'($urandom);
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("i%0d vec_ready", k), 32'(rdy[k]), 32'((m_busy[k] == 0) && !clear[k]));
                check($sformatf("i%0d done", k), 32'(done_o[k]), 32'(m_done[k]));
                check($sformatf("i%0d mismatch", k), 32'(mism[k]), 32'(m_mism[k]));
                check($sformatf("i%0d exp_c", k), 32'(expc[k]), 32'(m_exp[k]));
                check($sformatf("i%0d vec_cnt", k), 32'(vc_a[k]), 32'(m_vc[k]));
                check($sformatf("i%0d err_cnt", k), 32'(ec_a[k]), 32'(m_ec[k]));
                check($sformatf("i%0d pass", k), 32'(pass_o[k]), 32'(m_pass[k]));
            end
        end
    end

    task automatic wait_idle(input int k);
        int n = 0;
        while (m_busy[k] != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("i%0d idle wait", k), 32'(m_busy[k]), 32'd0);
    endtask

    // Called at a negedge; returns 2 time units after the negedge where done was seen.
    task automatic send(input int k, input logic [3:0] p, input logic [3:0] g,
                        input logic c0, input logic [3:0] fault, output int lat);
        wait_idle(k);
        fault_q[k]   = fault;
        vec_valid[k] = 1'b1;
        p_in[k]      = p;
        g_in[k]      = g;
        c0_in[k]     = c0;
        @(negedge clk);
        vec_valid[k] = 1'b0;
        p_in[k]      = 4'($urandom);
        g_in[k]      = 4'($urandom);
        c0_in[k]     = 1'($urandom);
        lat = 1;
        #2;
        while (done_o[k] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            #2;
            lat++;
        end
    endtask

    task automatic rand_run(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                clear[k]     = 1'b1;
                vec_valid[k] = 1'($urandom);
                @(negedge clk);
                clear[k]     = 1'b0;
                vec_valid[k] = 1'b0;
            end else begin
                wait_idle(k);
                fault_q[k]   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                vec_valid[k] = 1'b1;
                p_in[k]      = 4'($urandom);
                g_in[k]      = 4'($urandom);
                c0_in[k]     = 1'($urandom);
                @(negedge clk);
                vec_valid[k] = 1'b0;
            end
        end
        wait_idle(k);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            clear[k] = 1'b0; vec_valid[k] = 1'b0; p_in[k] = '0; g_in[k] = '0;
            c0_in[k] = 1'b0; fault_q[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("reset vec_cnt", 32'(vc_a[0]), 32'd0);
        check("reset exp_c", 32'(expc[0]), 32'd0);
        check("reset pass", 32'(pass_o[0]), 32'd0);
        check("reset vec_ready", 32'(rdy[0]), 32'd1);

        for (int i = 0; i < 6; i++) begin
            check($sformatf("model golden %0d", i), 32'(golden(TP[i], TG[i], TC[i])), 32'(TE[i]));
            send(0, TP[i], TG[i], TC[i], 4'd0, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d exp_c", i), 32'(expc[0]), 32'(TE[i]));
            check($sformatf("vec%0d mismatch", i), 32'(mism[0]), 32'd0);
        end
        check("six vec_cnt", 32'(vc_a[0]), 32'd6);
        check("six err_cnt", 32'(ec_a[0]), 32'd0);
        check("six pass", 32'(pass_o[0]), 32'd1);

        send(0, 4'b1101, 4'b0101, 1'b0, 4'b1000, lat);
        check("fault mismatch", 32'(mism[0]), 32'd1);
        check("fault err_cnt", 32'(ec_a[0]), 32'd1);
        check("fault pass", 32'(pass_o[0]), 32'd0);
        send(0, 4'b1100, 4'b1100, 1'b1, 4'd0, lat);
        check("post-fault mismatch", 32'(mism[0]), 32'd0);
        check("post-fault pass", 32'(pass_o[0]), 32'd0);
        check("post-fault vec_cnt", 32'(vc_a[0]), 32'd8);

        @(negedge clk);
        send(1, 4'b0101, 4'b1101, 1'b0, 4'd0, lat);
        check("settle0 latency", 32'(lat), 32'd2);
        check("settle0 exp_c", 32'(expc[1]), 32'b1101);
        @(negedge clk);
        wait_idle(1);
        vec_valid[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (done_o[1] === 1'b1) cnt++;
            p_in[1]  = 4'($urandom);
            g_in[1]  = 4'($urandom);
            c0_in[1] = 1'($urandom);
        end
        vec_valid[1] = 1'b0;
        check("settle0 done pulses", 32'(cnt), 32'd10);
        check("settle0 vec_cnt", 32'(vc_a[1]), 32'd11);

        @(negedge clk);
        wait_idle(0);
        vec_valid[0] = 1'b1;
        p_in[0] = 4'b1011; g_in[0] = 4'b0001; c0_in[0] = 1'b1;
        @(negedge clk);
        vec_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("midreset vec_ready", 32'(rdy[0]), 32'd1);
        check("midreset vec_cnt", 32'(vc_a[0]), 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            if (done_o[0] === 1'b1) cnt++;
        end
        check("midreset no done", 32'(cnt), 32'd0);

        send(0, 4'b1100, 4'b1000, 1'b1, 4'd0, lat);
        @(negedge clk);
        clear[0] = 1'b1; vec_valid[0] = 1'b1;
        p_in[0] = 4'b1111; g_in[0] = 4'b1111; c0_in[0] = 1'b1;
        #2;
        check("clear vec_ready", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        clear[0] = 1'b0; vec_valid[0] = 1'b0;
        #2;
        check("clear vec_cnt", 32'(vc_a[0]), 32'd0);
        check("clear exp_c kept", 32'(expc[0]), 32'b1000);
        check("clear vec_ready after", 32'(rdy[0]), 32'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            if (done_o[0] === 1'b1) cnt++;
        end
        check("clear no accept", 32'(cnt), 32'd0);

        for (int i = 0; i < 5; i++) begin
            send(2, 4'($urandom), 4'($urandom), 1'($urandom), 4'b0001, lat);
            check($sformatf("sat%0d latency", i), 32'(lat), 32'd4);
        end
        check("sat vec_cnt", 32'(vc_a[2]), 32'd3);
        check("sat err_cnt", 32'(ec_a[2]), 32'd3);
        check("sat pass", 32'(pass_o[2]), 32'd0);
        @(negedge clk);
        clear[2] = 1'b1;
        @(negedge clk);
        clear[2] = 1'b0;
        #2;
        check("sat clear vec_cnt", 32'(vc_a[2]), 32'd0);
        check("sat clear err_cnt", 32'(ec_a[2]), 32'd0);
        check("sat clear pass", 32'(pass_o[2]), 32'd0);
        @(negedge clk);

        for (int k = 0; k < NI; k++) rand_run(k, 150);

        repeat (5) @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
